// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: operand width, funct3 op codes, FSM state encoding
// and operand signedness helpers used by the multiply/divide unit.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CALC  = 2'd1;
    localparam state_t ST_FIXUP = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // rs1 is signed for everything except the fully unsigned ops.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the pipeline (master) and muldiv_unit (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds its payload stable until then, flush aborts any op.
interface muldiv_unit_if;
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [4:0]      in_rd_addr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd_addr;
    logic            out_we;
    state_t          dbg_state;

    modport master (
        output in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd_addr, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd_addr, out_we, dbg_state
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd_addr, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd_addr, out_we, dbg_state
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// 64-bit shift datapath: one shift-add multiply step or one restoring-division
// step per cycle on unsigned magnitudes. acc = {product} or {remainder, quotient}.
module muldiv_iter_core
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder shifted left with the next dividend bit; bit XLEN of
        // the difference is the borrow that decides whether to restore.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        acc_d     = acc_q;
        b_d       = b_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, opa_i};
            b_d   = opb_i;
        end else if (step_i) begin
            if (is_div_i) begin
                acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                       : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, handshake, divide special cases and
// sign fixup. Define MULDIV_FAST_MUL_EN for single-cycle multiplies at accept.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    state_t            state_q, state_d;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              sign_a_q, sign_b_q;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, core_load, core_step, fast_mul;
    logic              neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, fixup_res, quo_fix, rem_fix;
    logic [2*XLEN-1:0] core_acc, prod_fix;

    always_comb begin
        neg_a    = a_is_signed(bus.in_funct3) & bus.in_rs1_data[XLEN-1];
        neg_b    = b_is_signed(bus.in_funct3) & bus.in_rs2_data[XLEN-1];
        mag_a    = neg_a ? -bus.in_rs1_data : bus.in_rs1_data;
        mag_b    = neg_b ? -bus.in_rs2_data : bus.in_rs2_data;
        div_zero = bus.in_funct3[2] && (bus.in_rs2_data == '0);
        div_ovf  = bus.in_funct3[2] && !bus.in_funct3[0] &&
                   (bus.in_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_rs2_data == '1);
        // funct3[1] selects the remainder flavour of a divide.
        if (div_zero) begin
            special_res = bus.in_funct3[1] ? bus.in_rs1_data : '1;
        end else begin
            special_res = bus.in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

    always_comb begin
        fast_a    = {{XLEN{neg_a}}, bus.in_rs1_data};
        fast_b    = {{XLEN{neg_b}}, bus.in_rs2_data};
        fast_prod = fast_a * fast_b;
    end

    assign fast_mul = !bus.in_funct3[2];
`else
    assign fast_mul = 1'b0;
`endif

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -core_acc : core_acc;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
        rem_fix  = sign_a_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       fixup_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fixup_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fixup_res = quo_fix;
            default:                      fixup_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = (div_zero || div_ovf || fast_mul) ? ST_DONE : ST_CALC;
                ST_CALC:  if (cnt_q == 6'd31) state_d = ST_FIXUP;
                ST_FIXUP: state_d = ST_DONE;
                default:  if (bus.out_ready) state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = (state_q == ST_IDLE);
        bus.out_valid   = (state_q == ST_DONE);
        bus.out_we      = (state_q == ST_DONE) && (rd_q != 5'd0);
        bus.out_result  = result_q;
        bus.out_rd_addr = rd_q;
        bus.dbg_state   = state_q;
        accept          = (state_q == ST_IDLE) && bus.in_valid && !bus.flush;
        core_load       = accept;
        core_step       = (state_q == ST_CALC);
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            cnt_d = '0;
            if (div_zero || div_ovf) begin
                result_d = special_res;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_mul) begin
                result_d = (bus.in_funct3 == F3_MUL) ? fast_prod[XLEN-1:0]
                                                     : fast_prod[2*XLEN-1:XLEN];
            end
`endif
        end else if (state_q == ST_CALC) begin
            cnt_d = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
        end else if (state_q == ST_FIXUP) begin
            result_d = fixup_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q     <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            if (accept) begin
                f3_q     <= bus.in_funct3;
                rd_q     <= bus.in_rd_addr;
                sign_a_q <= neg_a;
                sign_b_q <= neg_b;
            end
        end
    end

    muldiv_iter_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (f3_q[2]),
        .opa_i    (mag_a),
        .opb_i    (mag_b),
        .acc_o    (core_acc)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus random ops, all checked against
// an arithmetic model of the M extension by one negedge compare process.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    muldiv_unit_if m();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] lat;
        logic [31:0] c0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_h;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   head_seen = 1'b0;
    bit   rand_ready = 1'b0;
    int   c_a, c_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] op_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'd1;
            return 32'd34;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 32'd1;
`else
        return 32'd34;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input bit track,
                         output int acc_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!m.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("issue_in_ready", 32'(m.in_ready), 32'd1);
        m.in_valid    = 1'b1;
        m.in_funct3   = f3;
        m.in_rs1_data = a;
        m.in_rs2_data = b;
        m.in_rd_addr  = rd;
        @(posedge clk);
        #1;
        m.in_valid = 1'b0;
        acc_cyc    = cyc;
        if (track) exp_q.push_back('{res: exp_res, rd: rd, lat: op_lat(f3, a, b), c0: cyc});
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(m.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(m.out_valid), 32'd0);
        chk({tag, "_out_we"}, 32'(m.out_we), 32'd0);
        chk({tag, "_out_result"}, m.out_result, 32'd0);
        chk({tag, "_out_rd_addr"}, 32'(m.out_rd_addr), 32'd0);
        chk({tag, "_state"}, 32'(m.dbg_state), 32'(ST_IDLE));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) begin
                chk("idle_out_valid", 32'(m.out_valid), 32'd0);
            end else begin
                mon_h = exp_q[0];
                chk("busy_in_ready", 32'(m.in_ready), 32'd0);
                if (m.out_valid) begin
                    if (!head_seen) begin
                        chk("latency", 32'(cyc) - mon_h.c0 + 32'd1, mon_h.lat);
                        head_seen = 1'b1;
                    end
                    chk("out_result", m.out_result, mon_h.res);
                    chk("out_rd_addr", 32'(m.out_rd_addr), 32'(mon_h.rd));
                    chk("out_we", 32'(m.out_we), 32'(mon_h.rd != 5'd0));
                    if (m.out_ready) begin
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                    end
                end else if (!head_seen && (32'(cyc) - mon_h.c0 + 32'd1 > mon_h.lat)) begin
                    chk("latency_overdue", 32'(cyc) - mon_h.c0 + 32'd1, mon_h.lat);
                    head_seen = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) m.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        m.in_valid    = 1'b0;
        m.in_funct3   = 3'b0;
        m.in_rs1_data = 32'b0;
        m.in_rs2_data = 32'b0;
        m.in_rd_addr  = 5'b0;
        m.flush       = 1'b0;
        m.out_ready   = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values("reset");

        chk("model_mul", model(F3_MUL, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_mulhu", model(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model_mulhsu", model(F3_MULHSU, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFF);
        chk("model_div", model(F3_DIV, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        chk("model_rem", model(F3_REM, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        chk("model_remu", model(F3_REMU, 32'd100, 32'd7), 32'd2);

        issue(F3_MUL,    32'h7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b1, c_a); drain();
        issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b1, c_a); drain();
        issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 1'b1, c_a); drain();
        issue(F3_MULHSU, 32'hFFFF_FFFF, 32'h2,         5'd4, 32'hFFFF_FFFF, 1'b1, c_a); drain();
        issue(F3_DIV,    32'hFFFF_FFF9, 32'h2,         5'd5, 32'hFFFF_FFFD, 1'b1, c_a); drain();
        issue(F3_REM,    32'hFFFF_FFF9, 32'h2,         5'd6, 32'hFFFF_FFFF, 1'b1, c_a); drain();
        issue(F3_DIVU,   32'd100,       32'd7,         5'd7, 32'd14,        1'b1, c_a); drain();
        issue(F3_REMU,   32'd100,       32'd7,         5'd8, 32'd2,         1'b1, c_a); drain();
        issue(F3_DIV,    32'd5,         32'd0,         5'd9, 32'hFFFF_FFFF, 1'b1, c_a); drain();
        issue(F3_REM,    32'd5,         32'd0,        5'd10, 32'd5,         1'b1, c_a); drain();
        issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, c_a); drain();
        issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,         1'b1, c_a); drain();

        // Writeback stalled for 10 cycles in DONE.
        m.out_ready = 1'b0;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, 1'b1, c_a);
        for (int i = 0; i < 100 && !m.out_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        m.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("retire_out_valid", 32'(m.out_valid), 32'd0);
        chk("retire_in_ready", 32'(m.in_ready), 32'd1);
        chk("retire_state", 32'(m.dbg_state), 32'(ST_IDLE));

        issue(F3_MUL, 32'd5, 32'd6, 5'd0, 32'd30, 1'b1, c_a); drain();

        // Back-to-back ops with writeback always ready.
        issue(F3_DIVU, 32'd50, 32'd5, 5'd14, 32'd10, 1'b1, c_a);
        issue(F3_DIVU, 32'd77, 32'd7, 5'd15, 32'd11, 1'b1, c_b);
        chk("throughput", 32'(c_b - c_a), 32'd35);
        drain();

        // Flush at CALC iteration 10.
        issue(F3_DIVU, 32'd1000, 32'd3, 5'd16, 32'd0, 1'b0, c_a);
        repeat (10) @(posedge clk);
        #1;
        chk("calc_state", 32'(m.dbg_state), 32'(ST_CALC));
        m.flush = 1'b1;
        @(posedge clk);
        #1;
        m.flush = 1'b0;
        chk("flush_state", 32'(m.dbg_state), 32'(ST_IDLE));
        chk("flush_out_valid", 32'(m.out_valid), 32'd0);
        chk("flush_in_ready", 32'(m.in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        issue(F3_MUL, 32'd3, 32'd4, 5'd17, 32'd12, 1'b1, c_a); drain();

        // Reset asserted while in FIXUP.
        issue(F3_DIVU, 32'd100, 32'd7, 5'd18, 32'd0, 1'b0, c_a);
        repeat (32) @(posedge clk);
        #1;
        chk("fixup_state", 32'(m.dbg_state), 32'(ST_FIXUP));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values("mid_reset");

        issue(F3_MUL, 32'd6, 32'd7, 5'd19, 32'd42, 1'b1, c_a); drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom_range(0, 31));
            issue(f3, a, b, rd, model(f3, a, b), 1'b1, c_a);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #3;
        m.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file. It consumes the two source operands read from the register file, along with funct3 and the destination register index. It computes the M-extension result over multiple cycles and presents it, together with its destination index, for writeback into the register file. A valid/ready handshake on both sides lets the pipeline stall while the unit is busy.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op presented this cycle.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_rs1_data  in  32  operand A, from register file Rs1 read port.
- in_rs2_data  in  32  operand B, from register file Rs2 read port.
- in_rd_addr  in  5  destination register index.
- flush  in  1  abort the in-flight op and return to IDLE.
- out_valid  out  1  result held and valid.
- out_ready  in  1  writeback accepts the result.
- out_result  out  32  computed result.
- out_rd_addr  out  5  destination register, captured at accept.
- out_we  out  1  out_valid && out_rd_addr != 0; drives the register-file write enable.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid is sampled high at a rising edge.
  - On accept, latch funct3 and rd_addr, then take operand magnitudes and sign flags according to the op's signedness.
- IDLE → CALC for a normal op.
- IDLE → DONE directly for:
  - divisor==0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = dividend.
  - signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- CALC, multiply: 32 iterations of shift-add into a 64-bit product.
- CALC, divide: 32 iterations of restoring division producing quotient and remainder.
  - A 6-bit iteration counter runs 0..31; CALC → FIXUP when counter==31.
- FIXUP:
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select the result: low 32 bits for MUL, high 32 bits for MULH*, quotient, or remainder.
  - FIXUP → DONE.
- DONE:
  - out_valid=1, with out_result and out_rd_addr stable.
  - DONE → IDLE on an edge where out_ready=1.
- flush=1 in any state forces IDLE at the next edge and deasserts out_valid; it overrides out_ready and in_valid in the same cycle.
- A new op cannot be accepted in the cycle its predecessor retires; in_ready rises the cycle after DONE → IDLE.

## Timing
- Reset values:
  - state=IDLE; in_ready=1.
  - out_valid=0, out_we=0.
  - out_result=0, out_rd_addr=0, counter=0.
- rst mid-operation discards all state at the next edge; rst takes priority over flush.
- Latency is measured from the accept edge E0 to the first cycle with out_valid=1:
  - normal op: 34 cycles (32 CALC, 1 FIXUP, 1 into DONE).
  - special-case divide: 1 cycle.
- Throughput: one op per 35 cycles best case, when out_ready is already high.
- All outputs are registered; there is no combinational path from in_* to out_*.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed product at accept and go IDLE → DONE with latency 1.
  - Divides are unchanged.
- Undefined: every multiply uses the iterative 34-cycle path.

## Structure
- Shared package riscv_pkg holds:
  - the funct3 constants for the eight M ops;
  - the state encoding localparams (IDLE=0, CALC=1, FIXUP=2, DONE=3);
  - XLEN.
- One natural sub-module, muldiv_iter_core: the 64-bit shift datapath that performs one multiply or divide step per cycle. muldiv_unit owns the FSM, the handshake, the special cases and sign fixup.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → out_result 0xFFFFFFEB at cycle 34; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5 at latency 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Hold out_ready=0 for 10 cycles in DONE → out_result/out_rd_addr stable, in_ready=0; out_ready=1 → IDLE next edge. rd=0 → out_we stays 0 while out_valid=1.
- flush at CALC iteration 10 → IDLE next edge, out_valid never asserts; a following MUL 3×4 → 12.
- rst asserted in FIXUP → all outputs return to reset values next edge; with MULDIV_FAST_MUL_EN defined, MUL 6×7 → 42 at latency 1.
